// File: rtl/mux12_rr_arbiter_if.sv
// Request/grant bundle between the 12 requesters, the mux and the arbiter.
interface mux12_rr_arbiter_if #(
   parameter int unsigned CNT_W = 4
);
   logic              en;
   logic [11:0]       req;
   logic [11:0]       grant;
   logic [3:0]        sel;
   logic              busy;
   logic [CNT_W-1:0]  hold_cnt;

   modport master (
      output en, req,
      input  grant, sel, busy, hold_cnt
   );

   modport slave (
      input  en, req,
      output grant, sel, busy, hold_cnt
   );
endinterface

// File: rtl/mux12_rr_arbiter.sv
// Round-robin arbiter owning the select of a 12-way mux, with a bounded tenure.
module mux12_rr_arbiter #(
   parameter int unsigned MAX_HOLD = 8,
   parameter int unsigned CNT_W    = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   mux12_rr_arbiter_if.slave     bus
);

   localparam int unsigned N_REQ = 12;
   localparam int unsigned IDX_W = 4;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_GRANT = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [N_REQ-1:0]   grant_q, grant_d;
   logic [IDX_W-1:0]   sel_q, sel_d;
   logic               busy_q, busy_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;

   // First requester at or after start, scanning upward modulo 12; returns {found, index}.
   function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [IDX_W-1:0] start);
      logic             found;
      logic [IDX_W-1:0] idx;
      logic [IDX_W:0]   sum;
      found = 1'b0;
      idx   = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         sum = (IDX_W+1)'(start) + (IDX_W+1)'(i);
         if (sum >= (IDX_W+1)'(N_REQ)) sum = sum - (IDX_W+1)'(N_REQ);
         if (!found && r[sum[IDX_W-1:0]]) begin
            found = 1'b1;
            idx   = sum[IDX_W-1:0];
         end
      end
      return {found, idx};
   endfunction

   logic [IDX_W:0]   pick;
   logic [IDX_W-1:0] scan_start;
   logic [IDX_W-1:0] next_ptr;
   logic             tenure_end;

   // Pointer after the current owner, wrapping 11 back to 0.
   always_comb begin
      next_ptr = (sel_q == IDX_W'(N_REQ - 1)) ? '0 : sel_q + IDX_W'(1);
   end

   // Tenure ends on release by the owner or on reaching the hold limit.
   always_comb begin
      tenure_end = !bus.req[sel_q] || (cnt_q == CNT_W'(MAX_HOLD));
   end

   // Search from the stored pointer when idle, from the post-owner pointer at tenure end.
   always_comb begin
      scan_start = (state_q == S_GRANT) ? next_ptr : ptr_q;
      pick       = rr_pick(bus.req, scan_start);
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      sel_d   = sel_q;
      busy_d  = busy_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;

      unique case (state_q)
         S_IDLE: begin
            if (bus.en && pick[IDX_W]) begin
               state_d = S_GRANT;
               grant_d = N_REQ'(1) << pick[IDX_W-1:0];
               sel_d   = pick[IDX_W-1:0];
               busy_d  = 1'b1;
               cnt_d   = CNT_W'(1);
            end else begin
               grant_d = '0;
               busy_d  = 1'b0;
               cnt_d   = '0;
            end
         end
         S_GRANT: begin
            if (!tenure_end) begin
               cnt_d = cnt_q + CNT_W'(1);
            end else begin
               ptr_d = next_ptr;
               if (bus.en && pick[IDX_W]) begin
                  grant_d = N_REQ'(1) << pick[IDX_W-1:0];
                  sel_d   = pick[IDX_W-1:0];
                  busy_d  = 1'b1;
                  cnt_d   = CNT_W'(1);
               end else begin
                  state_d = S_IDLE;
                  grant_d = '0;
                  busy_d  = 1'b0;
                  cnt_d   = '0;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         grant_q <= '0;
         sel_q   <= '0;
         busy_q  <= 1'b0;
         cnt_q   <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         sel_q   <= sel_d;
         busy_q  <= busy_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
      end
   end

   assign bus.grant    = grant_q;
   assign bus.sel      = sel_q;
   assign bus.busy     = busy_q;
   assign bus.hold_cnt = cnt_q;

endmodule

// File: tb/tb_mux12_rr_arbiter.sv
// Bench for mux12_rr_arbiter: directed vector table, wrap sequence, async reset, random vs model.
module tb_mux12_rr_arbiter;

   localparam int unsigned CNT_W = 4;
   localparam int          MAXA  = 8;
   localparam int          MAXB  = 2;

   logic clk;
   logic rst_n;

   mux12_rr_arbiter_if #(.CNT_W(CNT_W)) ba ();
   mux12_rr_arbiter_if #(.CNT_W(CNT_W)) bb ();

   mux12_rr_arbiter #(.MAX_HOLD(MAXA), .CNT_W(CNT_W)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ba)
   );

   mux12_rr_arbiter #(.MAX_HOLD(MAXB), .CNT_W(CNT_W)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: owner index (-1 when idle), tenure length, scan pointer, last select.
   typedef struct {
      int owner;
      int cnt;
      int ptr;
      int sel;
   } model_t;

   function automatic model_t step(input model_t m, input int maxh, input bit en,
                                   input logic [11:0] req);
      model_t r;
      int idx;
      r = m;
      if (r.owner >= 0) begin
         if (req[r.owner] && r.cnt < maxh) begin
            r.cnt = r.cnt + 1;
            return r;
         end
         r.ptr   = (r.owner + 1) % 12;
         r.owner = -1;
         r.cnt   = 0;
      end
      if (en) begin
         for (int k = 0; k < 12; k++) begin
            idx = (r.ptr + k) % 12;
            if (r.owner < 0 && req[idx]) begin
               r.owner = idx;
               r.sel   = idx;
               r.cnt   = 1;
            end
         end
      end
      return r;
   endfunction

   model_t ma = '{-1, 0, 0, 0};
   model_t mb = '{-1, 0, 0, 0};

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ma = '{-1, 0, 0, 0};
         mb = '{-1, 0, 0, 0};
      end else begin
         ma = step(ma, MAXA, ba.en, ba.req);
         mb = step(mb, MAXB, bb.en, bb.req);
      end
   end

   task automatic chk_model(input string nm, input logic [11:0] g, input logic [3:0] s,
                            input logic b, input logic [3:0] h, input model_t m, input int maxh);
      logic [11:0] eg;
      eg = (m.owner < 0) ? 12'h000 : (12'(1) << m.owner);
      chk({nm, ".grant"}, 32'(g), 32'(eg));
      chk({nm, ".sel"},   32'(s), 32'(m.sel));
      chk({nm, ".busy"},  32'(b), 32'(m.owner >= 0));
      chk({nm, ".hold"},  32'(h), 32'(m.cnt));
      chk({nm, ".hold_le_max"}, 32'(h <= 4'(maxh)), 32'd1);
      chk({nm, ".onehot0"}, 32'($countones(g) <= 1), 32'd1);
   endtask

   // Compare both DUTs against the model on every falling edge.
   always @(negedge clk) begin
      chk_model("mdl_a", ba.grant, ba.sel, ba.busy, ba.hold_cnt, ma, MAXA);
      chk_model("mdl_b", bb.grant, bb.sel, bb.busy, bb.hold_cnt, mb, MAXB);
   end

   typedef struct {
      bit          en;
      logic [11:0] req;
      logic [11:0] grant;
      logic [3:0]  sel;
      bit          busy;
      logic [3:0]  cnt;
   } vec_t;

   localparam int NV = 25;
   vec_t tbl [NV];

   function automatic vec_t mk(input bit en, input logic [11:0] req, input logic [11:0] g,
                               input logic [3:0] s, input bit b, input logic [3:0] c);
      vec_t v;
      v.en = en; v.req = req; v.grant = g; v.sel = s; v.busy = b; v.cnt = c;
      return v;
   endfunction

   initial begin
      // Single requester 5: grant next cycle, expire at 8, re-grant to itself.
      tbl[0] = mk(1, 12'h020, 12'h020, 4'd5, 1, 4'd1);
      for (int i = 1; i < 8; i++) tbl[i] = mk(1, 12'h020, 12'h020, 4'd5, 1, 4'(i + 1));
      tbl[8]  = mk(1, 12'h020, 12'h020, 4'd5, 1, 4'd1);
      // Requester 3 takes over on release of 5, then releases to idle.
      tbl[9]  = mk(1, 12'h008, 12'h008, 4'd3, 1, 4'd1);
      tbl[10] = mk(1, 12'h008, 12'h008, 4'd3, 1, 4'd2);
      tbl[11] = mk(1, 12'h008, 12'h008, 4'd3, 1, 4'd3);
      tbl[12] = mk(1, 12'h000, 12'h000, 4'd3, 0, 4'd0);
      tbl[13] = mk(1, 12'h000, 12'h000, 4'd3, 0, 4'd0);
      // 10 owns while 2 waits; 2 wins after 10, then 10 again.
      tbl[14] = mk(1, 12'h400, 12'h400, 4'd10, 1, 4'd1);
      tbl[15] = mk(1, 12'h404, 12'h400, 4'd10, 1, 4'd2);
      tbl[16] = mk(1, 12'h004, 12'h004, 4'd2, 1, 4'd1);
      tbl[17] = mk(1, 12'h400, 12'h400, 4'd10, 1, 4'd1);
      // Enable dropped during tenure of 7: tenure completes, then idle, then 8 wins.
      tbl[18] = mk(1, 12'h080, 12'h080, 4'd7, 1, 4'd1);
      tbl[19] = mk(0, 12'h180, 12'h080, 4'd7, 1, 4'd2);
      tbl[20] = mk(0, 12'h080, 12'h080, 4'd7, 1, 4'd3);
      tbl[21] = mk(0, 12'h100, 12'h000, 4'd7, 0, 4'd0);
      tbl[22] = mk(0, 12'h101, 12'h000, 4'd7, 0, 4'd0);
      tbl[23] = mk(1, 12'h101, 12'h100, 4'd8, 1, 4'd1);
      tbl[24] = mk(1, 12'h000, 12'h000, 4'd8, 0, 4'd0);
   end

   logic [11:0] rq;

   initial begin
      rst_n  = 1'b0;
      ba.en  = 1'b1;
      ba.req = 12'hFFF;
      bb.en  = 1'b1;
      bb.req = 12'hFFF;

      // Held in reset with every request high: nothing granted.
      repeat (3) begin
         @(negedge clk);
         chk("rst.grant", 32'(ba.grant), 32'h0);
         chk("rst.sel",   32'(ba.sel),   32'h0);
         chk("rst.busy",  32'(ba.busy),  32'h0);
         chk("rst.hold",  32'(ba.hold_cnt), 32'h0);
      end
      rst_n  = 1'b1;
      ba.req = 12'h000;
      bb.en  = 1'b0;
      bb.req = 12'h000;

      // Directed vector table on the MAX_HOLD=8 instance.
      for (int i = 0; i < NV; i++) begin
         ba.en  = tbl[i].en;
         ba.req = tbl[i].req;
         @(negedge clk);
         chk($sformatf("vec%0d.grant", i), 32'(ba.grant),    32'(tbl[i].grant));
         chk($sformatf("vec%0d.sel", i),   32'(ba.sel),      32'(tbl[i].sel));
         chk($sformatf("vec%0d.busy", i),  32'(ba.busy),     32'(tbl[i].busy));
         chk($sformatf("vec%0d.hold", i),  32'(ba.hold_cnt), 32'(tbl[i].cnt));
      end

      // All requesting with MAX_HOLD=2: each owner twice, ascending, no gaps.
      bb.en  = 1'b1;
      bb.req = 12'hFFF;
      for (int k = 0; k < 26; k++) begin
         @(negedge clk);
         chk($sformatf("wrap%0d.sel", k),  32'(bb.sel),      32'((k / 2) % 12));
         chk($sformatf("wrap%0d.busy", k), 32'(bb.busy),     32'd1);
         chk($sformatf("wrap%0d.hold", k), 32'(bb.hold_cnt), 32'((k % 2) + 1));
         chk($sformatf("wrap%0d.grant", k), 32'(bb.grant),   32'(12'(1) << ((k / 2) % 12)));
      end

      // Reset asserted mid-tenure clears outputs without a clock edge.
      #2 rst_n = 1'b0;
      #1;
      chk("arst.grant", 32'(bb.grant),    32'h0);
      chk("arst.sel",   32'(bb.sel),      32'h0);
      chk("arst.busy",  32'(bb.busy),     32'h0);
      chk("arst.hold",  32'(bb.hold_cnt), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Random traffic with persistent requests, checked against the model.
      rq = 12'h000;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(3) == 0) rq = 12'($urandom) & 12'($urandom) & 12'($urandom);
         ba.en  = ($urandom_range(7) != 0);
         bb.en  = ba.en;
         ba.req = rq;
         bb.req = rq;
         @(negedge clk);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
